// File: rtl/mainfsm_pkg.sv
// State codes and per-state datapath control constants for the multicycle main FSM.
package mainfsm_pkg;
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_UNKNOWN  = 4'd10;
  localparam logic [3:0] S_ALUWB2   = 4'd11;
  localparam logic [3:0] S_EXECUTEF = 4'd12;
  localparam logic [3:0] S_FPUWB    = 4'd13;

  localparam int CTRL_W = 14;

  typedef struct packed {
    logic       NextPC;
    logic       Branch;
    logic       MemW;
    logic       RegW;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ALUOp;
    logic       longFlag;
  } ctrl_t;

  //                         NBMRIA RS SA SB O L
  localparam ctrl_t C_NONE   = 14'b000000_00_00_00_0_0;
  localparam ctrl_t C_FETCH  = 14'b000000_10_01_10_0_0;
  localparam ctrl_t C_EXECR  = 14'b000000_00_00_00_1_0;
  localparam ctrl_t C_EXECI  = 14'b000000_00_00_01_1_0;
  localparam ctrl_t C_MEMADR = 14'b000000_00_00_01_0_0;
  localparam ctrl_t C_MEMACC = 14'b000001_00_00_00_0_0;
  localparam ctrl_t C_MEMWB  = 14'b000100_01_00_00_0_0;
  localparam ctrl_t C_REGW   = 14'b000100_00_00_00_0_0;
  localparam ctrl_t C_ALUWB2 = 14'b000100_00_00_00_0_1;
  localparam ctrl_t C_BRANCH = 14'b010000_10_00_01_0_0;
endpackage

// File: rtl/fpu_wait_timer.sv
// Counts cycles spent waiting on the FPU and flags the last allowed cycle.
module fpu_wait_timer #(
  parameter int CNT_W       = 8,
  parameter int FPU_TIMEOUT = 16
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             timeout
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign timeout = (cnt == CNT_W'(FPU_TIMEOUT - 1));
endmodule

// File: rtl/mainfsm_param.sv
// Multicycle main control FSM with memory wait states, FPU handshake/timeout
// and two-beat long-multiply writeback.
module mainfsm_param
  import mainfsm_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit FPU_EN      = 1'b1,
  parameter bit LONG_EN     = 1'b1,
  parameter int FPU_TIMEOUT = 16,
  parameter int CNT_W       = 8
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       long,
  input  logic       mem_ready,
  input  logic       fpu_done,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       FPUW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       longFlag,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       fpu_start,
  output logic       undef,
  output logic       fpu_fault,
  output logic       retire,
  output logic [3:0] state_o
);
  logic [3:0]       state, next;
  logic             fault_q, fault_set;
  logic             rdy, timeout;
  logic [CNT_W-1:0] cnt;
  ctrl_t            ctrl;
  logic             unused_funct;

  assign unused_funct = ^Funct[4:1];
  // Reset masks ready so the FETCH strobes stay low while reset is held.
  assign rdy = (MEM_WAIT_EN ? mem_ready : 1'b1) & reset_n;

  fpu_wait_timer #(.CNT_W(CNT_W), .FPU_TIMEOUT(FPU_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state != S_EXECUTEF),
    .en      (state == S_EXECUTEF),
    .cnt     (cnt),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      fault_q <= 1'b0;
    end else begin
      state   <= next;
      fault_q <= fault_set;
    end
  end

  always_comb begin
    next      = S_FETCH;
    fault_set = 1'b0;
    case (state)
      S_FETCH:    next = rdy ? S_DECODE : S_FETCH;
      S_DECODE:
        case (Op)
          2'b00:   next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   next = S_MEMADR;
          2'b10:   next = S_BRANCH;
          default: next = FPU_EN ? S_EXECUTEF : S_UNKNOWN;
        endcase
      S_EXECUTER, S_EXECUTEI: next = S_ALUWB;
      S_ALUWB:    next = (LONG_EN && long) ? S_ALUWB2 : S_FETCH;
      S_MEMADR:   next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:    next = rdy ? S_FETCH : S_MEMWR;
      S_EXECUTEF:
        if (fpu_done)     next = S_FPUWB;
        else if (timeout) begin
          next      = S_UNKNOWN;
          fault_set = 1'b1;
        end else          next = S_EXECUTEF;
      default:    next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl      = C_NONE;
    FPUW      = 1'b0;
    fpu_start = 1'b0;
    undef     = 1'b0;
    fpu_fault = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl         = C_FETCH;
        ctrl.IRWrite = rdy;
        ctrl.NextPC  = rdy;
      end
      S_DECODE:   ctrl = C_FETCH;
      S_EXECUTER: ctrl = C_EXECR;
      S_EXECUTEI: ctrl = C_EXECI;
      S_MEMADR:   ctrl = C_MEMADR;
      S_MEMRD:    ctrl = C_MEMACC;
      S_MEMWB: begin
        ctrl   = C_MEMWB;
        retire = 1'b1;
      end
      S_MEMWR: begin
        ctrl      = C_MEMACC;
        ctrl.MemW = rdy;
        retire    = rdy;
      end
      S_ALUWB: begin
        ctrl   = C_REGW;
        retire = !(LONG_EN && long);
      end
      S_ALUWB2: begin
        ctrl   = C_ALUWB2;
        retire = 1'b1;
      end
      S_BRANCH: begin
        ctrl   = C_BRANCH;
        retire = 1'b1;
      end
      S_EXECUTEF: fpu_start = (cnt == '0);
      S_FPUWB: begin
        ctrl   = C_REGW;
        FPUW   = 1'b1;
        retire = 1'b1;
      end
      S_UNKNOWN: begin
        undef     = 1'b1;
        fpu_fault = fault_q;
      end
      default: ;
    endcase
  end

  assign {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc,
          ResultSrc, ALUSrcA, ALUSrcB, ALUOp, longFlag} = ctrl;
  assign state_o = state;
endmodule

// File: tb/tb_mainfsm_param.sv
// Directed plus random checks of three differently parameterised FSM instances
// against a cycle-level behavioural model of the instruction flow.
module tb_mainfsm_param;
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
                 EXR = 6, EXI = 7, ALUWB = 8, BRANCH = 9, UNK = 10, ALUWB2 = 11,
                 EXF = 12, FPUWB = 13;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic long = 1'b0, mem_ready = 1'b0, fpu_done = 1'b0;

  logic [18:0] o  [3];
  logic [3:0]  st [3];

  bit pmw [3] = '{1'b1, 1'b1, 1'b0};
  bit pfe [3] = '{1'b1, 1'b1, 1'b0};
  bit ple [3] = '{1'b1, 1'b1, 1'b0};
  int pto [3] = '{16, 4, 16};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic IRWrite, AdrSrc, NextPC, RegW, MemW, FPUW, Branch, ALUOp, longFlag;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic fpu_start, undef, fpu_fault, retire;
    logic [3:0] state_o;
    mainfsm_param #(
      .MEM_WAIT_EN (g != 2), .FPU_EN (g != 2), .LONG_EN (g != 2),
      .FPU_TIMEOUT (g == 1 ? 4 : 16), .CNT_W (8)
    ) dut (
      .clk (clk), .reset_n (reset_n), .Op (Op), .Funct (Funct), .long (long),
      .mem_ready (mem_ready), .fpu_done (fpu_done),
      .IRWrite (IRWrite), .AdrSrc (AdrSrc), .NextPC (NextPC), .RegW (RegW),
      .MemW (MemW), .FPUW (FPUW), .Branch (Branch), .ALUOp (ALUOp),
      .longFlag (longFlag), .ALUSrcA (ALUSrcA), .ALUSrcB (ALUSrcB),
      .ResultSrc (ResultSrc), .fpu_start (fpu_start), .undef (undef),
      .fpu_fault (fpu_fault), .retire (retire), .state_o (state_o)
    );
    assign o[g] = {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
                   ALUSrcB, ALUOp, longFlag, FPUW, fpu_start, undef, fpu_fault, retire};
    assign st[g] = state_o;
  end

  int errors = 0, checks = 0;
  int ms [3], mc [3], nx [3];
  bit mf [3], nf [3];
  logic [18:0] eo [3];
  int n_retire, n_memw, n_start, n_exf1, n_fault1, n_undef2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Expected outputs and successor for instance k from the instruction-flow rules.
  task automatic eval(input int k);
    bit npc, br, mwr, rw, irw, adr, aop, lf, fw, fs, ud, ff, rt, rdy, to_hit;
    bit [1:0] rs, sa, sb;
    {npc, br, mwr, rw, irw, adr, aop, lf, fw, fs, ud, ff} = '0;
    rs = 0; sa = 0; sb = 0;
    rdy = reset_n && (pmw[k] ? mem_ready : 1'b1);
    nx[k] = FETCH; nf[k] = 0;
    case (ms[k])
      FETCH:  begin rs = 2; sa = 1; sb = 2; irw = rdy; npc = rdy; nx[k] = rdy ? DECODE : FETCH; end
      DECODE: begin
        rs = 2; sa = 1; sb = 2;
        case (Op)
          0: nx[k] = Funct[5] ? EXI : EXR;
          1: nx[k] = MEMADR;
          2: nx[k] = BRANCH;
          default: nx[k] = pfe[k] ? EXF : UNK;
        endcase
      end
      EXR:    begin aop = 1; nx[k] = ALUWB; end
      EXI:    begin sb = 1; aop = 1; nx[k] = ALUWB; end
      ALUWB:  begin rw = 1; nx[k] = (ple[k] && long) ? ALUWB2 : FETCH; end
      ALUWB2: begin rw = 1; lf = 1; end
      MEMADR: begin sb = 1; nx[k] = Funct[0] ? MEMRD : MEMWR; end
      MEMRD:  begin adr = 1; nx[k] = rdy ? MEMWB : MEMRD; end
      MEMWB:  begin rw = 1; rs = 1; end
      MEMWR:  begin adr = 1; mwr = rdy; nx[k] = rdy ? FETCH : MEMWR; end
      BRANCH: begin br = 1; rs = 2; sb = 1; end
      EXF: begin
        fs = (mc[k] == 0);
        to_hit = (mc[k] == pto[k] - 1);
        nx[k] = fpu_done ? FPUWB : (to_hit ? UNK : EXF);
        nf[k] = !fpu_done && to_hit;
      end
      FPUWB:  begin rw = 1; fw = 1; end
      UNK:    begin ud = 1; ff = mf[k]; end
      default: ;
    endcase
    rt = (nx[k] == FETCH) && ms[k] != FETCH && ms[k] != UNK;
    eo[k] = {npc, br, mwr, rw, irw, adr, rs, sa, sb, aop, lf, fw, fs, ud, ff, rt};
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin ms[k] = FETCH; mc[k] = 0; mf[k] = 0; end
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance model on posedge.
  task automatic cyc(input bit [1:0] op, input bit [5:0] fn, input bit lg, input bit rd, input bit dn);
    Op = op; Funct = fn; long = lg; mem_ready = rd; fpu_done = dn;
    #1;
    for (int k = 0; k < 3; k++) begin
      eval(k);
      chk($sformatf("state%0d", k), 32'(st[k]), 32'(ms[k]));
      chk($sformatf("outs%0d", k), 32'(o[k]), 32'(eo[k]));
    end
    n_retire += int'(o[0][0]);
    n_memw   += int'(o[0][16]);
    n_start  += int'(o[0][3]);
    n_exf1   += int'(st[1] == 4'd12);
    n_fault1 += int'(o[1][1]);
    n_undef2 += int'(o[2][2] && !o[2][1]);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        ms[k] = FETCH; mc[k] = 0; mf[k] = 0;
      end else begin
        mc[k] = (ms[k] == EXF && nx[k] == EXF) ? mc[k] + 1 : 0;
        mf[k] = nf[k];
        ms[k] = nx[k];
      end
    end
    @(negedge clk);
  endtask

  task automatic clr_counts();
    n_retire = 0; n_memw = 0; n_start = 0; n_exf1 = 0; n_fault1 = 0; n_undef2 = 0;
  endtask

  initial begin
    model_reset();
    clr_counts();
    @(negedge clk);
    // Reset held: FETCH decode with strobes low, even for the no-wait instance.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    reset_n = 1'b1;

    // Fetch wait states: three stalls then ready.
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Long immediate ALU op: two writeback beats, one retire.
    clr_counts();
    cyc(2'b00, 6'b100000, 1, 0, 0);
    repeat (3) cyc(2'b00, 6'b100000, 1, 0, 0);
    chk("long_retire", 32'(n_retire), 32'd1);
    cyc(0, 0, 0, 1, 0);

    // Store with two memory wait cycles: exactly one MemW strobe.
    clr_counts();
    cyc(2'b01, 6'b000000, 0, 0, 0);
    cyc(2'b01, 6'b000000, 0, 0, 0);
    cyc(2'b01, 6'b000000, 0, 0, 0);
    cyc(2'b01, 6'b000000, 0, 0, 0);
    cyc(2'b01, 6'b000000, 0, 1, 0);
    chk("memw_once", 32'(n_memw), 32'd1);
    cyc(0, 0, 0, 1, 0);

    // FPU op completing in its fifth cycle (instance 1 times out first).
    clr_counts();
    cyc(2'b11, 0, 0, 0, 0);
    repeat (4) cyc(2'b11, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 1);
    cyc(2'b11, 0, 0, 0, 0);
    chk("fpu_start_once", 32'(n_start), 32'd1);
    chk("exf_cycles_to4", 32'(n_exf1), 32'd4);
    chk("fault_seen_to4", 32'(n_fault1), 32'd1);
    cyc(0, 0, 0, 1, 0);

    // FPU never answers: full 16-cycle timeout on instance 0.
    clr_counts();
    cyc(2'b11, 0, 0, 0, 0);
    repeat (17) cyc(2'b11, 0, 0, 0, 0);
    chk("timeout_no_retire", 32'(n_retire), 32'd0);
    chk("timeout_state", 32'(st[0]), 32'd0);
    cyc(0, 0, 0, 1, 0);

    // Load stalled in MEMRD, then asynchronous reset mid-cycle.
    cyc(2'b01, 6'b000001, 0, 0, 0);
    cyc(2'b01, 6'b000001, 0, 0, 0);
    cyc(2'b01, 6'b000001, 0, 0, 0);
    chk("in_memrd", 32'(st[0]), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(st[0]), 32'd0);
    chk("async_rst_outs", 32'(o[0]), 32'(19'b000000_10_01_10_0_0_00000));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Op 11 with the FPU disabled: undefined, no fault flag.
    clr_counts();
    cyc(2'b11, 0, 0, 1, 0);
    cyc(2'b11, 0, 0, 1, 0);
    cyc(2'b11, 0, 0, 1, 0);
    chk("nofpu_undef", 32'(n_undef2), 32'd1);

    // Random instruction stream across all three instances.
    for (int i = 0; i < 600; i++)
      cyc(2'($urandom_range(0, 3)), 6'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
